// File: rtl/jk_pkg.sv
// JK flip-flop excitation encodings and the transition-to-excitation helper
// shared by the modulo counter and its per-bit cells.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Counting uses toggle-or-hold only: a bit that changes toggles, others hold.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    return (cur != nxt) ? JK_TOGGLE : JK_HOLD;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset; qb is its own
// register so it always equals ~q.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic q_next;

  always_comb begin
    q_next = q;
    case ({j, k})
      JK_HOLD:   q_next = q;
      JK_RESET:  q_next = 1'b0;
      JK_SET:    q_next = 1'b1;
      JK_TOGGLE: q_next = ~q;
      default:   q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= 1'b0;
      qb <= 1'b1;
    end else begin
      q  <= q_next;
      qb <= ~q_next;
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter: derives per-bit JK excitation and holds state
// in jk_cell instances. Optional gray output is enabled by JK_CNT_GRAY_EN.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
`ifdef JK_CNT_GRAY_EN
  ,
  output logic [WIDTH-1:0] gray
`endif
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count_val;
  logic             at_end;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;

  always_comb begin
    // Out-of-range load values saturate so q never reaches an unused code.
    load_val  = ({1'b0, din} >= MOD_EXT) ? MAX_Q : din;
    at_end    = up ? (q == MAX_Q) : (q == '0);
    if (up) count_val = at_end ? '0 : q + WIDTH'(1);
    else    count_val = at_end ? MAX_Q : q - WIDTH'(1);
    tc = en & ~load & at_end;
  end

  always_comb begin
    j_vec = '0;
    k_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (load)
        {j_vec[i], k_vec[i]} = {load_val[i], ~load_val[i]};
      else if (en)
        {j_vec[i], k_vec[i]} = jk_excite(q[i], count_val[i]);
      else
        {j_vec[i], k_vec[i]} = JK_HOLD;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[g]),
      .k   (k_vec[g]),
      .q   (q[g]),
      .qb  (qb[g])
    );
  end

  // tc already excludes load and hold edges, so it is exactly the wrap condition.
  always_ff @(posedge clk) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= tc;
  end

`ifdef JK_CNT_GRAY_EN
  logic [WIDTH-1:0] next_q;

  always_comb begin
    next_q = q;
    if (load)    next_q = load_val;
    else if (en) next_q = count_val;
  end

  always_ff @(posedge clk) begin
    if (rst) gray <= '0;
    else     gray <= next_q ^ (next_q >> 1);
  end
`endif

endmodule
